// File: rtl/pixel_serializer.sv
// Videotex pixel serializer: shifts out one character row byte per 8 pixel ticks,
// applying inverse/blink/conceal attributes, with a one-entry shadow buffer.
module pixel_serializer #(
  parameter int COLOR_BITS   = 3,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pixel_enable,
  input  logic                  display_enable,
  input  logic                  frame_start,
  input  logic                  load,
  input  logic [7:0]            pixels,
  input  logic [COLOR_BITS-1:0] fg,
  input  logic [COLOR_BITS-1:0] bg,
  input  logic                  inverse,
  input  logic                  blink,
  input  logic                  conceal,
  input  logic                  reveal,
  output logic                  next_req,
  output logic [COLOR_BITS-1:0] out_color,
  output logic                  underrun
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [COLOR_BITS-1:0] fg;
    logic [COLOR_BITS-1:0] bg;
    logic                  inv;
    logic                  blk;
    logic                  conc;
  } attr_t;

  logic [7:0]            shadow_pix_q, shadow_pix_d;
  attr_t                 shadow_attr_q, shadow_attr_d;
  logic                  shadow_full_q, shadow_full_d;
  attr_t                 cur_attr_q, cur_attr_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [COLOR_BITS-1:0] out_color_q, out_color_d;
  logic                  next_req_q, next_req_d;
  logic                  underrun_q, underrun_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  logic                  xfer_s;
  logic                  cur_pix_s;
  attr_t                 attr_sel_s;
  logic                  on_s;

  // Next-state logic: pixel stepping, shadow handover, colour and blink timebase
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    out_color_d   = out_color_q;
    cur_attr_d    = cur_attr_q;
    underrun_d    = underrun_q;
    next_req_d    = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    cur_pix_s     = 1'b0;
    attr_sel_s    = cur_attr_q;
    xfer_s        = pixel_enable & display_enable & (bit_cnt_q == 3'd0);

    if (!display_enable) begin
      out_color_d = '0;
      bit_cnt_d   = 3'd0;
    end else if (pixel_enable) begin
      if (bit_cnt_q == 3'd0) begin
        next_req_d = 1'b1;
        if (shadow_full_q) begin
          cur_pix_s  = shadow_pix_q[7];
          attr_sel_s = shadow_attr_q;
          shift_d    = {shadow_pix_q[6:0], 1'b0};
        end else begin
          // Empty shadow: blank pixels but keep the previous cell's colours
          cur_pix_s  = 1'b0;
          attr_sel_s = cur_attr_q;
          shift_d    = 8'h00;
          underrun_d = 1'b1;
        end
        cur_attr_d = attr_sel_s;
      end else begin
        cur_pix_s  = shift_q[7];
        attr_sel_s = cur_attr_q;
        shift_d    = {shift_q[6:0], 1'b0};
      end
      bit_cnt_d   = bit_cnt_q + 3'd1;
      out_color_d = on_s ? attr_sel_s.fg : attr_sel_s.bg;
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  assign on_s = (cur_pix_s ^ attr_sel_s.inv)
              & ~((attr_sel_s.blk & blink_phase_q) | (attr_sel_s.conc & ~reveal));

  // A transfer and a load in the same clock: old shadow is consumed, new one stays full
  assign shadow_full_d = load | (shadow_full_q & ~xfer_s);
  assign shadow_pix_d  = load ? pixels : shadow_pix_q;
  assign shadow_attr_d = load ? {fg, bg, inverse, blink, conceal} : shadow_attr_q;

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_pix_q  <= 8'h00;
      shadow_attr_q <= '0;
      shadow_full_q <= 1'b0;
      cur_attr_q    <= '0;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      out_color_q   <= '0;
      next_req_q    <= 1'b0;
      underrun_q    <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      shadow_pix_q  <= shadow_pix_d;
      shadow_attr_q <= shadow_attr_d;
      shadow_full_q <= shadow_full_d;
      cur_attr_q    <= cur_attr_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      out_color_q   <= out_color_d;
      next_req_q    <= next_req_d;
      underrun_q    <= underrun_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign next_req  = next_req_q;
  assign out_color = out_color_q;
  assign underrun  = underrun_q;

endmodule
